// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared port ids, read-tag type and parameter range checks
package dmem_arbiter_pkg;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DBG  = 1'b1;

    localparam int RD_LAT_MIN   = 1;
    localparam int RD_LAT_MAX   = 4;
    localparam int LOCK_MAX_MIN = 1;
    localparam int LOCK_MAX_MAX = 15;

    typedef struct packed {
        logic valid;
        logic port;
    } rd_tag_t;

    function automatic bit cfg_ok(input int rd_lat, input int lock_max);
        return rd_lat >= RD_LAT_MIN && rd_lat <= RD_LAT_MAX &&
               lock_max >= LOCK_MAX_MIN && lock_max <= LOCK_MAX_MAX;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rd_tag_pipe.sv
// rd_tag_pipe: DEPTH-deep shift register of read tags matching memory read latency
module rd_tag_pipe
    import dmem_arbiter_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    reset_n,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out,
    output logic    any_valid
);

    rd_tag_t stage [DEPTH];

    // shift a tag in every cycle; reset drops every in-flight read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    // head of the pipe lines up with mem_rdata; any valid stage means a read is pending
    always_comb begin
        tag_out   = stage[DEPTH-1];
        any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) any_valid = any_valid | stage[i].valid;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter with bounded lock sharing one data memory between two ports
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int LOCK_MAX = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    if (!cfg_ok(RD_LAT, LOCK_MAX)) begin : g_cfg_err
        $error("dmem_arbiter: RD_LAT must be 1..4 and LOCK_MAX 1..15");
    end

    logic [1:0] req;
    logic [1:0] we;
    logic [1:0] lock;
    logic       any_req;
    logic       win;
    logic       at_max;
    logic       force_own;
    logic       last_gnt;
    logic       lock_vld;
    logic       lock_port;
    logic [3:0] lock_cnt;
    logic       pipe_busy;
    rd_tag_t    tag_in;
    rd_tag_t    tag_head;

    // pick the winner: held lock first (unless its quota is spent and the other port waits), then round-robin
    always_comb begin
        req       = {m1_req, m0_req};
        we        = {m1_we, m0_we};
        lock      = {m1_lock, m0_lock};
        any_req   = reset_n && (m0_req || m1_req);
        at_max    = lock_cnt == 4'(LOCK_MAX);
        force_own = lock_vld && req[lock_port] && !(at_max && req[~lock_port]);
        win       = force_own ? lock_port : (&req) ? ~last_gnt : req[1];
        m0_gnt    = any_req && win == PORT_CORE;
        m1_gnt    = any_req && win == PORT_DBG;
        mem_we    = any_req && we[win];
        mem_addr  = !any_req ? '0 : win ? m1_addr : m0_addr;
        mem_wdata = !any_req ? '0 : win ? m1_wdata : m0_wdata;
        tag_in    = '{valid: any_req && !we[win], port: win};
        m0_rvalid = tag_head.valid && tag_head.port == PORT_CORE;
        m1_rvalid = tag_head.valid && tag_head.port == PORT_DBG;
        m0_rdata  = m0_rvalid ? mem_rdata : '0;
        m1_rdata  = m1_rvalid ? mem_rdata : '0;
        busy      = pipe_busy || lock_vld;
    end

    // track the last winner and the lock owner; a lock at its quota restarts when the owner keeps winning
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_gnt  <= 1'b1;
            lock_vld  <= 1'b0;
            lock_port <= 1'b0;
            lock_cnt  <= 4'd0;
        end else if (any_req) begin
            last_gnt  <= win;
            lock_vld  <= lock[win];
            lock_port <= win;
            lock_cnt  <= !lock[win] ? 4'd0 :
                         (lock_vld && lock_port == win && !at_max) ? lock_cnt + 4'd1 : 4'd1;
        end else begin
            lock_vld  <= 1'b0;
            lock_cnt  <= 4'd0;
        end
    end

    rd_tag_pipe #(.DEPTH(RD_LAT)) u_rd_tag_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .tag_in    (tag_in),
        .tag_out   (tag_head),
        .any_valid (pipe_busy)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter at RD_LAT 1 and 3
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

    logic        m0_gnt_a, m0_rvalid_a, m1_gnt_a, m1_rvalid_a, mem_we_a, busy_a;
    logic [31:0] m0_rdata_a, m1_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
    logic        m0_gnt_b, m0_rvalid_b, m1_gnt_b, m1_rvalid_b, mem_we_b, busy_b;
    logic [31:0] m0_rdata_b, m1_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] rd_a;
    logic [31:0] pb [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.RD_LAT(1), .LOCK_MAX(4)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt_a), .m0_rvalid(m0_rvalid_a), .m0_rdata(m0_rdata_a),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt_a), .m1_rvalid(m1_rvalid_a), .m1_rdata(m1_rdata_a),
        .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a),
        .busy(busy_a)
    );

    dmem_arbiter #(.RD_LAT(3), .LOCK_MAX(4)) u_dut3 (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt_b), .m0_rvalid(m0_rvalid_b), .m0_rdata(m0_rdata_b),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt_b), .m1_rvalid(m1_rvalid_b), .m1_rdata(m1_rdata_b),
        .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b),
        .busy(busy_b)
    );

    // memory models: preload during reset, synchronous read with 1 and 3 cycle latency
    always @(posedge clk) begin
        if (!reset_n) begin
            mem_a[8'h10] <= 32'hDEADBEEF;
            mem_a[8'h14] <= 32'h11111111;
            mem_b[8'h10] <= 32'hDEADBEEF;
        end else begin
            if (mem_we_a) mem_a[mem_addr_a[7:0]] <= mem_wdata_a;
            if (mem_we_b) mem_b[mem_addr_b[7:0]] <= mem_wdata_b;
        end
        rd_a  <= mem_a[mem_addr_a[7:0]];
        pb[0] <= mem_b[mem_addr_b[7:0]];
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end

    assign mem_rdata_a = rd_a;
    assign mem_rdata_b = pb[2];

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = 32'h10; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = '0;    m1_wdata = '0;
        #2;
        chk1("rst_gnt0", m0_gnt_a, 1'b0);
        chk1("rst_memwe", mem_we_a, 1'b0);
        chk("rst_memaddr", mem_addr_a, 32'h0);
        chk1("rst_busy", busy_a, 1'b0);
        chk1("rst_rvalid0", m0_rvalid_a, 1'b0);
        chk("rst_rdata0", m0_rdata_a, 32'h0);
        nxt();
        nxt();
        reset_n = 1'b1;
        // both ports read every cycle: m0 takes the first conflict, then alternate
        m0_req = 1'b1; m0_addr = 32'h10;
        m1_req = 1'b1; m1_addr = 32'h14;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk1("rr_gnt0", m0_gnt_a, i % 2 == 0);
            chk1("rr_gnt1", m1_gnt_a, i % 2 == 1);
            chk("rr_addr", mem_addr_a, (i % 2 == 0) ? 32'h10 : 32'h14);
            if (i > 0) begin
                chk1("rr_rvalid0", m0_rvalid_a, i % 2 == 1);
                chk1("rr_rvalid1", m1_rvalid_a, i % 2 == 0);
                chk("rr_rdata0", m0_rdata_a, (i % 2 == 1) ? 32'hDEADBEEF : 32'h0);
            end
            nxt();
        end
        m0_req = 1'b0; m1_req = 1'b0;
        #1;
        chk1("rr_tail_rvalid1", m1_rvalid_a, 1'b1);
        chk("rr_tail_rdata1", m1_rdata_a, 32'h11111111);
        chk1("rr_tail_rvalid0", m0_rvalid_a, 1'b0);
        // single m0 read
        nxt();
        m0_req = 1'b1; m0_addr = 32'h10;
        #1;
        chk1("rd_gnt0", m0_gnt_a, 1'b1);
        chk1("rd_gnt1", m1_gnt_a, 1'b0);
        chk("rd_addr", mem_addr_a, 32'h10);
        chk1("rd_memwe", mem_we_a, 1'b0);
        nxt();
        m0_req = 1'b0;
        #1;
        chk1("rd_rvalid0", m0_rvalid_a, 1'b1);
        chk("rd_rdata0", m0_rdata_a, 32'hDEADBEEF);
        chk1("rd_rvalid1", m1_rvalid_a, 1'b0);
        chk1("rd_busy", busy_a, 1'b1);
        nxt();
        chk1("rd_done_busy", busy_a, 1'b0);
        chk1("rd_done_rvalid0", m0_rvalid_a, 1'b0);
        // m1 locked store burst while m0 waits: 4 locked grants then hand-over
        nxt();
        m0_req = 1'b1; m0_addr = 32'h10; m0_we = 1'b0;
        m1_req = 1'b1; m1_we = 1'b1; m1_lock = 1'b1;
        for (int j = 0; j < 4; j++) begin
            m1_addr = 32'h20 + 32'(4 * j);
            m1_wdata = 32'hA0 + 32'(j);
            #1;
            chk1("lk_gnt1", m1_gnt_a, 1'b1);
            chk1("lk_gnt0", m0_gnt_a, 1'b0);
            chk1("lk_memwe", mem_we_a, 1'b1);
            chk("lk_addr", mem_addr_a, 32'h20 + 32'(4 * j));
            chk("lk_wdata", mem_wdata_a, 32'hA0 + 32'(j));
            chk1("lk_busy", busy_a, j > 0);
            nxt();
        end
        m1_addr = 32'h30; m1_wdata = 32'hA4;
        #1;
        chk1("lk_handover_gnt0", m0_gnt_a, 1'b1);
        chk1("lk_handover_gnt1", m1_gnt_a, 1'b0);
        chk1("lk_handover_memwe", mem_we_a, 1'b0);
        chk("lk_handover_addr", mem_addr_a, 32'h10);
        nxt();
        m0_req = 1'b0;
        for (int j = 4; j < 8; j++) begin
            m1_addr = 32'h20 + 32'(4 * j);
            m1_wdata = 32'hA0 + 32'(j);
            #1;
            chk1("lk2_gnt1", m1_gnt_a, 1'b1);
            chk1("lk2_memwe", mem_we_a, 1'b1);
            chk("lk2_addr", mem_addr_a, 32'h20 + 32'(4 * j));
            if (j == 4) begin
                chk1("lk2_rvalid0", m0_rvalid_a, 1'b1);
                chk("lk2_rdata0", m0_rdata_a, 32'hDEADBEEF);
            end
            nxt();
        end
        m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0;
        #1;
        chk1("lk_end_busy", busy_a, 1'b1);
        chk1("lk_end_rvalid1", m1_rvalid_a, 1'b0);
        nxt();
        chk1("lk_rel_busy", busy_a, 1'b0);
        // m0 store then m1 load of the same address
        nxt();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h40; m0_wdata = 32'h55;
        #1;
        chk1("raw_gnt0", m0_gnt_a, 1'b1);
        chk1("raw_memwe", mem_we_a, 1'b1);
        chk("raw_wdata", mem_wdata_a, 32'h55);
        nxt();
        m0_req = 1'b0; m0_we = 1'b0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h40;
        #1;
        chk1("raw_gnt1", m1_gnt_a, 1'b1);
        chk1("raw_rd_memwe", mem_we_a, 1'b0);
        chk1("raw_wr_rvalid0", m0_rvalid_a, 1'b0);
        nxt();
        m1_req = 1'b0;
        #1;
        chk1("raw_rvalid1", m1_rvalid_a, 1'b1);
        chk("raw_rdata1", m1_rdata_a, 32'h55);
        // RD_LAT=3 read in flight, then asynchronous reset drops it
        nxt();
        m0_req = 1'b1; m0_addr = 32'h10;
        #1;
        chk1("l3_gnt0", m0_gnt_b, 1'b1);
        nxt();
        chk1("l3_busy", busy_b, 1'b1);
        reset_n = 1'b0;
        #1;
        chk1("l3_rst_gnt0", m0_gnt_b, 1'b0);
        chk("l3_rst_addr", mem_addr_b, 32'h0);
        chk1("l3_rst_memwe", mem_we_b, 1'b0);
        chk1("l3_rst_busy", busy_b, 1'b0);
        chk1("l3_rst_rvalid0", m0_rvalid_b, 1'b0);
        chk("l3_rst_rdata0", m0_rdata_b, 32'h0);
        m0_req = 1'b0;
        nxt();
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk1("l3_post_rvalid0", m0_rvalid_b, 1'b0);
            chk1("l3_post_rvalid1", m1_rvalid_b, 1'b0);
            nxt();
        end
        // idle: nothing granted, memory bus quiet
        for (int k = 0; k < 10; k++) begin
            #1;
            chk1("idle_gnt0", m0_gnt_a, 1'b0);
            chk1("idle_gnt1", m1_gnt_a, 1'b0);
            chk1("idle_memwe", mem_we_a, 1'b0);
            chk("idle_addr", mem_addr_a, 32'h0);
            chk("idle_wdata", mem_wdata_a, 32'h0);
            chk1("idle_busy", busy_a, 1'b0);
            nxt();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
